// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Dual-issue fetch controller. Owns the fetch PC and decides each cycle whether
// fetch advances by one instruction pair, stalls, or is redirected. Four
// redirect requesters are arbitrated by age (W older than E, lane 1 older than
// lane 2). If a redirect arrives while the instruction memory is still busy,
// the target is parked in a pending register until the access completes. The
// data returned by that access is on the wrong path.
//
// Ports
//   clk, rst_n          clock (rising edge) / async active-low reset
//   i_StallD            decode/hazard stall request
//   i_IMemReady         instruction memory finished the access at o_PCF
//   i_BranchTaken{1,2}E E-stage branch taken, lane 1/2
//   i_ALUResult{1,2}E   E-stage branch targets
//   i_PCSrc{1,2}W       W-stage PC write, lane 1/2
//   i_Result{1,2}W      W-stage PC write values
//   o_PCF               registered fetch PC (imem address)
//   o_PCPlus8F          o_PCF + FETCH_INC
//   o_StallF            fetch PC held this cycle
//   o_FetchValid        pair at o_PCF may enter decode this cycle
//   o_FlushD/E/M        pipeline register flushes
//   o_KillLane2E/W      squash younger lane 2 in E / W
//   o_RedirectPending   a redirect is waiting on the memory
//   o_RedirectCnt       wrapping count of accepted redirects
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int                 D_WIDTH   = 32,
  parameter int                 FETCH_INC = 8,
  parameter logic [D_WIDTH-1:0] RESET_PC  = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_StallD,
  input  logic               i_IMemReady,
  input  logic               i_BranchTaken1E,
  input  logic               i_BranchTaken2E,
  input  logic [D_WIDTH-1:0] i_ALUResult1E,
  input  logic [D_WIDTH-1:0] i_ALUResult2E,
  input  logic               i_PCSrc1W,
  input  logic               i_PCSrc2W,
  input  logic [D_WIDTH-1:0] i_Result1W,
  input  logic [D_WIDTH-1:0] i_Result2W,
  output logic [D_WIDTH-1:0] o_PCF,
  output logic [D_WIDTH-1:0] o_PCPlus8F,
  output logic               o_StallF,
  output logic               o_FetchValid,
  output logic               o_FlushD,
  output logic               o_FlushE,
  output logic               o_FlushM,
  output logic               o_KillLane2E,
  output logic               o_KillLane2W,
  output logic               o_RedirectPending,
  output logic [CNT_W-1:0]   o_RedirectCnt
);

  localparam int NUM_REQ = 4;

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [D_WIDTH-1:0]              pc_q, pc_d;
  logic [D_WIDTH-1:0]              pend_q, pend_d;
  logic [CNT_W-1:0]                cnt_q;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0][D_WIDTH-1:0] req_tgt;
  logic                            redir;
  logic                            w_req;
  logic [D_WIDTH-1:0]              tgt;
  logic [D_WIDTH-1:0]              pc_inc;

  // Index 0 is the oldest requester; lower index wins.
  assign req     = {i_BranchTaken2E, i_BranchTaken1E, i_PCSrc2W, i_PCSrc1W};
  assign req_tgt = {i_ALUResult2E, i_ALUResult1E, i_Result2W, i_Result1W};

  // Scan youngest to oldest so the oldest active request is written last.
  always_comb begin
    tgt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) tgt = req_tgt[i];
  end

  assign redir  = |req;
  assign w_req  = req[0] | req[1];
  assign pc_inc = pc_q + D_WIDTH'(FETCH_INC);

  // Flush/kill go out with the request; requesters hold their requests.
  assign o_FlushD     = redir;
  assign o_FlushE     = redir;
  assign o_FlushM     = w_req;
  assign o_KillLane2W = i_PCSrc1W;
  assign o_KillLane2E = i_BranchTaken1E & ~w_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redir && !i_IMemReady) state_d = PEND;
      PEND:    if (i_IMemReady)           state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs
  always_comb begin
    o_StallF     = 1'b1;
    o_FetchValid = 1'b0;
    case (state_q)
      RUN: begin
        if (redir) begin
          // redirect overrides a decode stall
          o_StallF = ~i_IMemReady;
        end else begin
          o_StallF     = i_StallD | ~i_IMemReady;
          o_FetchValid = i_IMemReady;
        end
      end
      // the access completing in PEND returns a wrong-path pair
      PEND:    o_StallF = ~i_IMemReady;
      default: o_StallF = 1'b1;
    endcase
  end

  // PC / pending-target datapath
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    case (state_q)
      RUN: begin
        if (redir) begin
          if (i_IMemReady) pc_d   = tgt;
          else             pend_d = tgt;
        end else if (!o_StallF) begin
          pc_d = pc_inc;
        end
      end
      PEND: begin
        // a new redirect comes from an older, unflushed instruction: it wins
        if (redir)       pend_d = tgt;
        if (i_IMemReady) pc_d   = redir ? tgt : pend_q;
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      if (redir) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_PCF             = pc_q;
  assign o_PCPlus8F        = pc_inc;
  assign o_RedirectPending = (state_q == PEND);
  assign o_RedirectCnt     = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl: directed + random stimulus against a behavioural model of the
// fetch controller (PC value, pending flag/target, redirect count).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int D_WIDTH = 32;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall_d, mem_rdy;
  logic               bt1, bt2, src1, src2;
  logic [D_WIDTH-1:0] alu1, alu2, res1, res2;
  logic [D_WIDTH-1:0] pcf, pcp8;
  logic               stall_f, fvalid, fl_d, fl_e, fl_m, kill_e, kill_w, pending;
  logic [CNT_W-1:0]   rcnt;

  fetch_ctrl #(.D_WIDTH(D_WIDTH), .FETCH_INC(8), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_StallD(stall_d), .i_IMemReady(mem_rdy),
    .i_BranchTaken1E(bt1), .i_BranchTaken2E(bt2),
    .i_ALUResult1E(alu1), .i_ALUResult2E(alu2),
    .i_PCSrc1W(src1), .i_PCSrc2W(src2),
    .i_Result1W(res1), .i_Result2W(res2),
    .o_PCF(pcf), .o_PCPlus8F(pcp8), .o_StallF(stall_f), .o_FetchValid(fvalid),
    .o_FlushD(fl_d), .o_FlushE(fl_e), .o_FlushM(fl_m),
    .o_KillLane2E(kill_e), .o_KillLane2W(kill_w),
    .o_RedirectPending(pending), .o_RedirectCnt(rcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  // model state
  logic [D_WIDTH-1:0] m_pc;
  bit                 m_pend_vld;
  logic [D_WIDTH-1:0] m_pend;
  logic [CNT_W-1:0]   m_cnt;

  // comb outputs sampled in the last cycle
  logic s_stall, s_fv, s_fd, s_fe, s_fm, s_ke, s_kw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bt1 = 0; bt2 = 0; src1 = 0; src2 = 0; stall_d = 0;
    alu1 = '0; alu2 = '0; res1 = '0; res2 = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend_vld = 0; m_pend = '0; m_cnt = '0;
  endtask

  // Called at posedge+1 with inputs set; checks at posedge+4, advances the
  // model past the next edge.
  task automatic cycle();
    bit                 rd;
    logic [D_WIDTH-1:0] t, npc;
    bit                 e_st, e_fv, e_fm, e_ke;
    #3;
    rd = 1;
    if      (src1) t = res1;
    else if (src2) t = res2;
    else if (bt1)  t = alu1;
    else if (bt2)  t = alu2;
    else begin rd = 0; t = '0; end
    e_fm = src1 | src2;
    e_ke = bt1 & ~src1 & ~src2;
    npc  = m_pc;
    if (!m_pend_vld) begin
      if (!rd) begin
        e_st = stall_d | ~mem_rdy;
        e_fv = mem_rdy;
        if (!e_st) npc = m_pc + 32'd8;
      end else begin
        e_fv = 0;
        e_st = ~mem_rdy;
        if (mem_rdy) npc = t;
      end
    end else begin
      e_fv = 0;
      e_st = ~mem_rdy;
      if (mem_rdy) npc = rd ? t : m_pend;
    end
    if (chk_en) begin
      check("pcf",     pcf,     m_pc);
      check("pcplus8", pcp8,    m_pc + 32'd8);
      check("stall_f", 32'(stall_f), 32'(e_st));
      check("fvalid",  32'(fvalid),  32'(e_fv));
      check("flush_kill", {27'd0, fl_d, fl_e, fl_m, kill_e, kill_w},
                          {27'd0, rd, rd, e_fm, e_ke, src1});
      check("pending", 32'(pending), 32'(m_pend_vld));
      check("rcnt",    32'(rcnt),    32'(m_cnt));
    end
    s_stall = stall_f; s_fv = fvalid; s_fd = fl_d; s_fe = fl_e;
    s_fm = fl_m; s_ke = kill_e; s_kw = kill_w;
    @(posedge clk); #1;
    if (!m_pend_vld) begin
      if (rd && !mem_rdy) begin m_pend_vld = 1; m_pend = t; end
    end else begin
      if (rd) m_pend = t;
      if (mem_rdy) m_pend_vld = 0;
    end
    m_pc  = npc;
    m_cnt = m_cnt + CNT_W'(rd);
  endtask

  initial begin
    // reset state
    idle(); mem_rdy = 1; rst_n = 0;
    model_reset();
    #1;
    check("rst_pcf", pcf, 32'h0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cnt", 32'(rcnt), 32'd0);
    check("rst_fvalid", 32'(fvalid), 32'd1);
    mem_rdy = 0;
    #1 rst_n = 1;
    @(posedge clk); #1;

    // sequential fetch
    mem_rdy = 1;
    repeat (4) cycle();
    check("seq_pc", pcf, 32'h20);
    check("seq_fv", 32'(s_fv), 32'd1);

    // decode stall
    stall_d = 1;
    cycle();
    check("stall_f", 32'(s_stall), 32'd1);
    cycle();
    check("stall_hold", pcf, 32'h20);
    stall_d = 0;
    cycle();
    check("stall_adv", pcf, 32'h28);

    // W lane 2 beats E lane 1
    src2 = 1; res2 = 32'h200; bt1 = 1; alu1 = 32'h100;
    cycle();
    check("prio_w2_pc", pcf, 32'h200);
    check("prio_w2_fm", 32'(s_fm), 32'd1);
    check("prio_w2_ke", 32'(s_ke), 32'd0);
    check("prio_w2_cnt", 32'(rcnt), 32'd1);

    // W lane 1 beats W lane 2
    idle(); src1 = 1; res1 = 32'h304; src2 = 1; res2 = 32'h340;
    cycle();
    check("prio_w1_pc", pcf, 32'h304);
    check("prio_w1_kw", 32'(s_kw), 32'd1);

    // E lane 1 alone, overriding a decode stall
    idle(); bt1 = 1; alu1 = 32'h40; stall_d = 1;
    cycle();
    check("e1_pc", pcf, 32'h40);
    check("e1_flush", {28'd0, s_fd, s_fe, s_fm, s_ke}, {28'd0, 4'b1101});

    // pending redirect overwritten by a W redirect
    idle(); mem_rdy = 0; bt1 = 1; alu1 = 32'h80;
    cycle();
    check("pend_enter", 32'(pending), 32'd1);
    idle();
    cycle();
    src1 = 1; res1 = 32'hC0;
    cycle();
    idle(); mem_rdy = 1;
    cycle();
    check("pend_fv", 32'(s_fv), 32'd0);
    check("pend_pc", pcf, 32'hC0);
    check("pend_exit", 32'(pending), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      mem_rdy = ($urandom_range(0, 3) != 0);
      stall_d = ($urandom_range(0, 3) == 0);
      src1 = ($urandom_range(0, 9) == 0);
      src2 = ($urandom_range(0, 9) == 0);
      bt1  = ($urandom_range(0, 6) == 0);
      bt2  = ($urandom_range(0, 6) == 0);
      res1 = $urandom; res2 = $urandom; alu1 = $urandom; alu2 = $urandom;
      cycle();
    end

    // reset while pending
    idle(); mem_rdy = 0; bt1 = 1; alu1 = 32'h500;
    cycle();
    check("pre_rst_pending", 32'(pending), 32'd1);
    idle();
    rst_n = 0;
    #1;
    check("midrst_pcf", pcf, 32'h0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_cnt", 32'(rcnt), 32'd0);
    model_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    mem_rdy = 1;
    cycle();

    // counter wrap: 2^CNT_W redirects
    chk_en = 0;
    for (int n = 0; n < (1 << CNT_W); n++) begin
      bt2 = 1; alu2 = 32'(n) << 3;
      cycle();
    end
    chk_en = 1;
    idle();
    check("wrap_cnt", 32'(rcnt), 32'd0);
    cycle();
    check("wrap_pc", pcf, 32'h7FFF8 + 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
